// File: rtl/add_arb_pkg.sv
// rtl/add_arb_pkg.sv - shared FSM encoding and sizing for the add/sub arbiter
package add_arb_pkg;

    localparam int NREQ          = 2;
    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/add_sub_unit.sv
// rtl/add_sub_unit.sv - combinational two's-complement add/sub with signed overflow
module add_sub_unit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_b_eff;

    // Subtraction is A + ~B + 1; overflow looks at the sign of the effective B.
    assign w_b_eff = i_sub ? ~i_b : i_b;
    assign o_sum   = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, i_sub};
    assign o_ovf   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/add_arbiter.sv
// rtl/add_arbiter.sv - round-robin sharing of one add/sub unit; ADD_ARB_SATURATE_EN clamps on overflow
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_sub,
    output logic [NREQ-1:0]         resp_valid,
    input  logic [NREQ-1:0]         resp_ready,
    output logic [WIDTH-1:0]        resp_out,
    output logic                    resp_ovf,
    output logic                    busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic             r_gnt;
    logic             r_sub;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;

    logic             w_any;
    logic             w_gnt;
    logic             w_accept;
    logic             w_done;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;

    add_sub_unit #(.WIDTH(WIDTH)) u_add_sub (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_sub (r_sub),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    // Pointer holder wins when valid; otherwise the other requester may take the slot.
    assign w_any    = |req_valid;
    assign w_gnt    = req_valid[r_rr_ptr] ? r_rr_ptr : ~r_rr_ptr;
    assign w_accept = (r_state == ST_IDLE) && w_any && !reset;
    assign w_done   = (r_state == ST_RESP) && resp_ready[r_gnt];

    always_comb begin
        w_res = w_sum;
`ifdef ADD_ARB_SATURATE_EN
        // On overflow the true result has the sign of A.
        if (w_ovf) begin
            w_res = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        resp_valid  = '0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    req_ready[w_gnt] = 1'b1;
                    w_state_nxt      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid[r_gnt] = 1'b1;
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
            r_gnt    <= 1'b0;
            r_sub    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_gnt <= w_gnt;
                r_a   <= w_gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
                r_b   <= w_gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
                r_sub <= req_sub[w_gnt];
            end
            if (r_state == ST_EXEC) begin
                r_out <= w_res;
                r_ovf <= w_ovf;
            end
            if (w_done) begin
                r_rr_ptr <= ~r_gnt;
            end
        end
    end

    assign resp_out = r_out;
    assign resp_ovf = r_ovf;

endmodule

// File: tb/tb_add_arbiter.sv
// tb/tb_add_arbiter.sv - randomized self-checking bench for add_arbiter against an integer model
module tb_add_arbiter;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_a;
    logic [2*W-1:0] req_b;
    logic [1:0]     req_sub;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [W-1:0]   resp_out;
    logic           resp_ovf;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    int pend_v [2];
    int pa     [2];
    int pb     [2];
    int ps     [2];
    int m_ptr;

    always #5 clk = ~clk;

    add_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    function automatic void model_op(input int a, input int b, input int sub,
                                     output logic [W-1:0] out, output logic ovf);
        int t;
        t   = (sub != 0) ? a - b : a + b;
        ovf = (t > 31) || (t < -32);
        out = t[W-1:0];
`ifdef ADD_ARB_SATURATE_EN
        if (ovf) out = (t > 0) ? 6'b011111 : 6'b100000;
`endif
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]       = (pend_v[i] != 0);
            req_a[i*W +: W]    = pa[i][W-1:0];
            req_b[i*W +: W]    = pb[i][W-1:0];
            req_sub[i]         = (ps[i] != 0);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b, input int sub);
        pend_v[i] = 1;
        pa[i]     = a;
        pb[i]     = b;
        ps[i]     = sub;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        pend_v[0]  = 0;
        pend_v[1]  = 0;
        resp_ready = '0;
        drive_reqs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0;
    endtask

    // One full request/execute/response exchange; expects the FSM idle on entry.
    task automatic transact(input string tag, input int hold, output int g);
        logic [1:0]   exp_oh;
        logic [W-1:0] eo;
        logic         eovf;
        drive_reqs();
        if (pend_v[0] != 0 && pend_v[1] != 0) g = m_ptr;
        else if (pend_v[0] != 0)              g = 0;
        else                                  g = 1;
        exp_oh    = '0;
        exp_oh[g] = 1'b1;
        model_op(pa[g], pb[g], ps[g], eo, eovf);
        @(negedge clk);
        n_tests++;
        if (req_ready !== exp_oh) begin
            n_fail++;
            $display("FAIL %s grant: req_ready=%b want=%b", tag, req_ready, exp_oh);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_busy: busy=%b want=0", tag, busy);
        end
        @(posedge clk); #1;
        pend_v[g] = 0;
        drive_reqs();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1 || resp_valid !== 2'b00 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL %s exec: busy=%b resp_valid=%b req_ready=%b want 1/00/00",
                     tag, busy, resp_valid, req_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== exp_oh || resp_out !== eo || resp_ovf !== eovf) begin
            n_fail++;
            $display("FAIL %s resp: valid=%b out=%0d ovf=%b want valid=%b out=%0d ovf=%b",
                     tag, resp_valid, $signed(resp_out), resp_ovf, exp_oh, $signed(eo), eovf);
        end
        for (int k = 0; k < hold; k++) begin
            resp_ready        = '0;
            resp_ready[1 - g] = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            n_tests++;
            if (resp_valid !== exp_oh || resp_out !== eo || resp_ovf !== eovf ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s stall%0d: valid=%b out=%0d ovf=%b rdy=%b busy=%b want valid=%b out=%0d ovf=%b rdy=00 busy=1",
                         tag, k, resp_valid, $signed(resp_out), resp_ovf, req_ready, busy,
                         exp_oh, $signed(eo), eovf);
            end
        end
        resp_ready        = '0;
        resp_ready[g]     = 1'b1;
        resp_ready[1 - g] = 1'($urandom % 2);
        @(posedge clk); #1;
        resp_ready = '0;
        m_ptr      = 1 - g;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 1, 2, 0);
        set_req(1, 3, 4, 1);
        resp_ready = '0;
        drive_reqs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 2'b00 || resp_valid !== 2'b00 || busy !== 1'b0 ||
            resp_out !== '0 || resp_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b rv=%b busy=%b out=%0d ovf=%b want all zero",
                     req_ready, resp_valid, busy, resp_out, resp_ovf);
        end
        do_reset();
    endtask

    task automatic test_single();
        int g;
        set_req(0, 5, 7, 0);
        transact("single_5p7", 0, g);
    endtask

    task automatic test_fairness();
        int g;
        int prev;
        do_reset();
        set_req(0, 20, 3, 1);
        set_req(1, -10, 4, 0);
        transact("tie_first", 0, g);
        n_tests++;
        if (g !== 0) begin
            n_fail++;
            $display("FAIL tie_after_reset: winner=%0d want=0", g);
        end
        prev = g;
        for (int i = 0; i < 6; i++) begin
            set_req(prev, int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
                    int'($urandom % 2));
            transact("tie_alt", 0, g);
            n_tests++;
            if (g !== 1 - prev) begin
                n_fail++;
                $display("FAIL tie_alternate: winner=%0d want=%0d", g, 1 - prev);
            end
            prev = g;
        end
        pend_v[0] = 0;
        pend_v[1] = 0;
    endtask

    task automatic test_overflow();
        int g;
        for (int r = 0; r < 2; r++) begin
            set_req(r, 31, 1, 0);    transact("ovf_31p1", r, g);
            set_req(r, -32, 1, 1);   transact("ovf_m32m1", 0, g);
            set_req(r, 0, -32, 1);   transact("ovf_0mm32", 0, g);
            set_req(r, -1, -32, 1);  transact("edge_m1mm32", 0, g);
            set_req(r, -32, -32, 0); transact("ovf_m32pm32", 0, g);
        end
    endtask

    task automatic test_stall();
        int g;
        set_req(1, 13, -7, 1);
        set_req(0, 2, 2, 0);
        transact("stall5_a", 5, g);
        transact("stall5_b", 5, g);
    endtask

    task automatic test_reset_mid();
        int g;
        set_req(0, 3, 4, 0);
        transact("pre_reset", 0, g);
        set_req(0, 9, 9, 0);
        drive_reqs();
        @(posedge clk); #1;
        pend_v[0] = 0;
        set_req(1, 1, 1, 0);
        drive_reqs();
        req_valid = 2'b11;
        reset     = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 2'b00 || busy !== 1'b0 || resp_out !== '0 ||
            resp_ovf !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid: rv=%b busy=%b out=%0d ovf=%b rdy=%b want all zero",
                     resp_valid, busy, resp_out, resp_ovf, req_ready);
        end
        reset     = 1'b0;
        pend_v[0] = 0;
        pend_v[1] = 0;
        m_ptr     = 0;
        drive_reqs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (resp_valid !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL no_stale_resp: rv=%b busy=%b want 00/0", resp_valid, busy);
            end
        end
        @(posedge clk); #1;
        set_req(0, 6, 1, 1);
        set_req(1, 6, 1, 0);
        transact("tie_after_mid_reset", 0, g);
        n_tests++;
        if (g !== 0) begin
            n_fail++;
            $display("FAIL ptr_after_mid_reset: winner=%0d want=0", g);
        end
        pend_v[1] = 0;
    endtask

    task automatic test_random();
        int g;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (pend_v[i] == 0 && ($urandom % 2) == 1)
                    set_req(i, int'($urandom_range(0, 63)) - 32,
                            int'($urandom_range(0, 63)) - 32, int'($urandom % 2));
            end
            if (pend_v[0] == 0 && pend_v[1] == 0)
                set_req(int'($urandom % 2), int'($urandom_range(0, 63)) - 32,
                        int'($urandom_range(0, 63)) - 32, int'($urandom % 2));
            transact("random", (($urandom % 4) == 0) ? int'($urandom_range(1, 3)) : 0, g);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = '0;
        resp_ready = '0;
        pend_v[0]  = 0;
        pend_v[1]  = 0;
        m_ptr      = 0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_fairness();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
